// File: rtl/pcpu_mem_responder.sv
// pcpu_mem_responder
//   Instruction and data memories for a small CPU, plus a host loader that can
//   burst-fill either memory while the CPU is held off.
//
// Ports
//   clock, reset        system clock; asynchronous active-high reset
//   i_addr / i_data     instruction fetch port (combinational read of imem)
//   d_addr / d_wdata /
//   d_we / d_rdata      CPU data port (combinational read, clocked write of dmem)
//   ld_start / ld_sel   host starts a burst into imem (0) or dmem (1)
//   ld_valid / ld_data /
//   ld_last / ld_ready  host word stream
//   ld_done             one-cycle burst-complete pulse
//   ld_ovf              sticky: burst hit the memory end without ld_last
//   ld_count / ld_sum   words accepted and their modulo-2^DW sum
//   cpu_hold            CPU must not run while high
//   fsm_state           loader FSM state (0 idle, 1 load, 2 done) for observation
//
// Handshake: a host word is accepted on a rising edge where ld_valid and
// ld_ready are both 1. ld_ready is high exactly while the FSM is in LOAD, so
// ld_valid outside LOAD is ignored and the host may hold it high freely.
module pcpu_mem_responder #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_data,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_we,
  output logic [DW-1:0] d_rdata,
  input  logic          ld_start,
  input  logic          ld_sel,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          ld_ovf,
  output logic [AW:0]   ld_count,
  output logic [DW-1:0] ld_sum,
  output logic          cpu_hold,
  output logic [1:0]    fsm_state
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW:0]   COUNT_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          sel;
  logic [AW-1:0] ptr;

  // Memories are deliberately outside the reset domain so a reset keeps
  // whatever has already been loaded.
  logic [DW-1:0] imem [DEPTH];
  logic [DW-1:0] dmem [DEPTH];

  logic accept;
  assign accept = (state == LOAD) && ld_valid;

  assign i_data    = imem[i_addr];
  assign d_rdata   = dmem[d_addr];
  assign fsm_state = state;

  // Loader FSM with registered handshake/status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      ptr      <= '0;
      ld_count <= '0;
      ld_sum   <= '0;
      ld_ovf   <= 1'b0;
      ld_done  <= 1'b0;
      ld_ready <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            sel      <= ld_sel;
            ptr      <= '0;
            ld_count <= '0;
            ld_sum   <= '0;
            ld_ovf   <= 1'b0;
            state    <= LOAD;
            ld_ready <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            if (ld_count != COUNT_MAX) ld_count <= ld_count + (AW+1)'(1);
            ld_sum <= ld_sum + ld_data;
            // The pointer never wraps: the top address ends the burst even
            // without ld_last, and that case is flagged as an overflow.
            if (ld_last || (ptr == LAST_ADDR)) begin
              if (!ld_last) ld_ovf <= 1'b1;
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          ld_done  <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          ld_done  <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  // Memory writes. CPU stores are dropped for the whole LOAD state so a
  // loader word can never be overwritten by a concurrent store.
  always_ff @(posedge clock) begin
    if (accept && !sel) imem[ptr] <= ld_data;
    if (accept && sel) begin
      dmem[ptr] <= ld_data;
    end else if (d_we && (state != LOAD)) begin
      dmem[d_addr] <= d_wdata;
    end
  end

endmodule
